// File: rtl/div_unit_if.sv
// Request/response bundle for div_unit.
//   master: drives start, op_code, input_a, input_b; observes out, busy, done
//   slave : the divider side of the same signals
interface div_unit_if;
  logic        start;
  logic [1:0]  op_code;  // 00 DIV, 01 DIVU, 10 REM, 11 REMU
  logic [31:0] input_a;  // dividend
  logic [31:0] input_b;  // divisor
  logic [31:0] out;      // quotient or remainder, registered
  logic        busy;
  logic        done;

  modport master (
    output start,
    output op_code,
    output input_a,
    output input_b,
    input  out,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  op_code,
    input  input_a,
    input  input_b,
    output out,
    output busy,
    output done
  );
endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit RV32M divider (DIV/DIVU/REM/REMU). Restoring shift-subtract,
// one quotient bit per clock, behind a start/busy/done handshake.
//   clock : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : div_unit_if.slave (start, op_code, input_a, input_b -> out, busy, done)
// Optional build macro DIV_FAST_PATH_EN: a zero divisor or the signed-overflow
// pair finishes straight from IDLE with the architectural result (done one
// cycle after start). Without it every request takes the 32-step path.
module div_unit (
  input  logic      clock,
  input  logic      reset,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic        rem_sel_q;  // 1: return remainder
  logic        neg_quo_q;  // negate quotient on completion
  logic        neg_rem_q;  // negate remainder on completion
  logic [31:0] div_q;      // divisor magnitude
  logic [31:0] quo_q;      // dividend shifting out, quotient shifting in
  logic [31:0] rem_q;      // partial remainder; always < divisor so bit 32 is implicit zero
  logic [5:0]  cnt_q;
  logic [31:0] out_q;
  logic        busy_q;
  logic        done_q;

  // Operand decode at the start edge.
  logic        is_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  always_comb begin
    is_signed = ~bus.op_code[0];
    a_mag     = (is_signed && bus.input_a[31]) ? 32'd0 - bus.input_a : bus.input_a;
    b_mag     = (is_signed && bus.input_b[31]) ? 32'd0 - bus.input_b : bus.input_b;
  end

  // One restoring step plus the sign fix-up applied on the final step.
  logic [32:0] rem_sh;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] result;

  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    quo_nx = {quo_q[30:0], 1'b0};
    rem_nx = rem_sh[31:0];
    if (rem_sh >= {1'b0, div_q}) begin
      // Difference is below the divisor, so the low 32 bits hold it exactly.
      rem_nx    = rem_sh[31:0] - div_q;
      quo_nx[0] = 1'b1;
    end
    quo_fix = neg_quo_q ? 32'd0 - quo_nx : quo_nx;
    rem_fix = neg_rem_q ? 32'd0 - rem_nx : rem_nx;
    result  = rem_sel_q ? rem_fix : quo_fix;
  end

`ifdef DIV_FAST_PATH_EN
  logic        fast_hit;
  logic        b_zero;
  logic [31:0] fast_res;

  always_comb begin
    b_zero   = (bus.input_b == 32'd0);
    fast_hit = b_zero ||
               (is_signed && bus.input_a == 32'h8000_0000 && bus.input_b == 32'hFFFF_FFFF);
    if (b_zero) begin
      fast_res = bus.op_code[1] ? bus.input_a : 32'hFFFF_FFFF;
    end else begin
      fast_res = bus.op_code[1] ? 32'd0 : 32'h8000_0000;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div_q     <= 32'd0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      cnt_q     <= 6'd0;
      out_q     <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            rem_sel_q <= bus.op_code[1];
            // A zero divisor keeps the all-ones quotient the loop produces.
            neg_quo_q <= is_signed && (bus.input_a[31] ^ bus.input_b[31]) &&
                         (bus.input_b != 32'd0);
            neg_rem_q <= is_signed && bus.input_a[31];
            div_q     <= b_mag;
            quo_q     <= a_mag;
            rem_q     <= 32'd0;
            cnt_q     <= 6'd0;
            busy_q    <= 1'b1;
`ifdef DIV_FAST_PATH_EN
            if (fast_hit) begin
              out_q   <= fast_res;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StRun;
            end
`else
            state_q   <= StRun;
`endif
          end
        end
        StRun: begin
          quo_q <= quo_nx;
          rem_q <= rem_nx;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            out_q   <= result;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= 6'd0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
